// File: rtl/rv32_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I core: FSM states,
// instruction classes, opcode values and the select/op encodings driven
// toward the ALU control, PC mux and writeback mux. Imported by the main
// control FSM, the opcode classifier, the ALU control and the datapath.
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALU_WAIT, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_FENCE
  } iclass_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [1:0] ALUOP_F3  = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_SUB = 2'b11;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_ALU = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic       SRCA_RS1 = 1'b0;
  localparam logic       SRCA_PC  = 1'b1;
  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  typedef struct packed {
    logic [1:0] op;
    logic       f3z;
    logic       src_a;
    logic [1:0] src_b;
  } alu_sel_t;

  // ALU operand/op selection for each instruction class. Address-forming
  // classes force ADD via the funct3 mask.
  function automatic alu_sel_t alu_sel_for(iclass_e c);
    alu_sel_t s;
    s = '0;
    case (c)
      CL_LOAD, CL_STORE, CL_JALR: s = '{ALUOP_F3, 1'b1, SRCA_RS1, SRCB_IMM};
      CL_OPIMM:                   s = '{ALUOP_F3, 1'b0, SRCA_RS1, SRCB_IMM};
      CL_OP:                      s = '{ALUOP_R,  1'b0, SRCA_RS1, SRCB_RS2};
      CL_BRANCH:                  s = '{ALUOP_BR, 1'b0, SRCA_RS1, SRCB_RS2};
      CL_AUIPC, CL_JAL:           s = '{ALUOP_F3, 1'b1, SRCA_PC,  SRCB_IMM};
      default:                    s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rv32_op_classify.sv
// Combinational opcode classifier.
//  i_opcode   in  7  IR[6:0]
//  o_cls      out    instruction class
//  o_illegal  out 1  opcode is not a supported RV32I major opcode
module rv32_op_classify
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output iclass_e    o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls     = CL_FENCE;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_LOAD:   o_cls = CL_LOAD;
      OPC_STORE:  o_cls = CL_STORE;
      OPC_OPIMM:  o_cls = CL_OPIMM;
      OPC_OP:     o_cls = CL_OP;
      OPC_BRANCH: o_cls = CL_BRANCH;
      OPC_JAL:    o_cls = CL_JAL;
      OPC_JALR:   o_cls = CL_JALR;
      OPC_LUI:    o_cls = CL_LUI;
      OPC_AUIPC:  o_cls = CL_AUIPC;
      OPC_FENCE:  o_cls = CL_FENCE;
      default:    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences fetch / decode / execute / memory / writeback. alu_op and the
// operand selects are driven in S_EXEC and held in S_ALU_WAIT so the
// registered ALU control decoder has settled when aluout_we fires.
//  clk, rst                 clock, async active-high reset
//  opcode                   IR[6:0], sampled into the class register in S_DECODE
//  br_taken                 branch condition, used in S_ALU_WAIT
//  imem_ready/dmem_ready    memory handshakes
//  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src
//  alu_op, alu_f3_zero, alu_src_a, alu_src_b, aluout_we
//  rf_we, wb_sel, trap (sticky until rst), busy (low only in trap)
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int MEM_TO_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_f3_zero,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       aluout_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic       busy
);

  // Counter value at which one more unanswered request cycle traps.
  localparam logic [MEM_TO_W-1:0] TO_LAST = {{(MEM_TO_W-1){1'b1}}, 1'b0};

  state_e                r_state, w_next;
  iclass_e               r_cls, w_cls;
  logic                  w_illegal;
  logic [MEM_TO_W-1:0]   r_to_cnt;
  logic                  w_wait, w_to_hit;
  alu_sel_t              w_alu;

  rv32_op_classify u_cls (
    .i_opcode  (opcode),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  assign w_alu    = alu_sel_for(r_cls);
  // A request outstanding without ready this cycle.
  assign w_wait   = (r_state == S_FETCH && !imem_ready) ||
                    (r_state == S_MEM   && !dmem_ready);
  assign w_to_hit = w_wait && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Counter is zero whenever no request is pending, so it is always clear
  // on entry to S_FETCH / S_MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_to_cnt <= '0;
    else if (w_wait) r_to_cnt <= r_to_cnt + 1'b1;
    else             r_to_cnt <= '0;
  end

  // Class is latched once; later opcode changes do not affect sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cls <= CL_FENCE;
    else if (r_state == S_DECODE)  r_cls <= w_cls;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:
        if (imem_ready)    w_next = S_DECODE;
        else if (w_to_hit) w_next = S_TRAP;
      S_DECODE:
        if (w_illegal)              w_next = S_TRAP;
        else if (w_cls == CL_FENCE) w_next = S_FETCH;
        else if (w_cls == CL_LUI)   w_next = S_WB;
        else                        w_next = S_EXEC;
      S_EXEC: w_next = S_ALU_WAIT;
      S_ALU_WAIT:
        case (r_cls)
          CL_BRANCH:         w_next = S_FETCH;
          CL_LOAD, CL_STORE: w_next = S_MEM;
          default:           w_next = S_WB;
        endcase
      S_MEM:
        if (dmem_ready)    w_next = (r_cls == CL_STORE) ? S_FETCH : S_WB;
        else if (w_to_hit) w_next = S_TRAP;
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are forced idle while rst is high so requests drop immediately.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PCSRC_PC4;
    alu_op      = ALUOP_F3;
    alu_f3_zero = 1'b0;
    alu_src_a   = SRCA_RS1;
    alu_src_b   = SRCB_RS2;
    aluout_we   = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = WB_ALU;
    trap        = 1'b0;
    busy        = 1'b1;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            pc_src = PCSRC_PC4;
          end
        end
        S_EXEC: begin
          alu_op      = w_alu.op;
          alu_f3_zero = w_alu.f3z;
          alu_src_a   = w_alu.src_a;
          alu_src_b   = w_alu.src_b;
        end
        S_ALU_WAIT: begin
          alu_op      = w_alu.op;
          alu_f3_zero = w_alu.f3z;
          alu_src_a   = w_alu.src_a;
          alu_src_b   = w_alu.src_b;
          aluout_we   = 1'b1;
          case (r_cls)
            CL_BRANCH: begin pc_we = br_taken; pc_src = PCSRC_BR;  end
            CL_JAL:    begin pc_we = 1'b1;     pc_src = PCSRC_BR;  end
            CL_JALR:   begin pc_we = 1'b1;     pc_src = PCSRC_ALU; end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (r_cls == CL_STORE);
        end
        S_WB: begin
          rf_we = 1'b1;
          case (r_cls)
            CL_LOAD:         wb_sel = WB_MEM;
            CL_JAL, CL_JALR: wb_sel = WB_PC4;
            CL_LUI:          wb_sel = WB_IMM;
            default:         wb_sel = WB_ALU;
          endcase
        end
        S_TRAP: begin
          trap = 1'b1;
          busy = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
module tb_rv32_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, br_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, aluout_we, rf_we, trap, busy;
  logic       alu_f3_zero, alu_src_a;
  logic [1:0] pc_src, alu_op, alu_src_b, wb_sel;

  logic       rst3 = 1'b1, irdy3 = 1'b0, drdy3 = 1'b0;
  logic [6:0] op3 = 7'b0;
  logic       imem_req3, dmem_req3, dmem_we3, ir_we3, pc_we3, aluout_we3, rf_we3, trap3, busy3;
  logic       f3z3, srca3;
  logic [1:0] pcsrc3, aluop3, srcb3, wbsel3;

  int n_chk = 0, n_pass = 0;

  rv32_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_f3_zero(alu_f3_zero), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluout_we(aluout_we), .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap), .busy(busy)
  );

  rv32_multicycle_ctrl #(.MEM_TO_W(3)) dut3 (
    .clk(clk), .rst(rst3), .opcode(op3), .br_taken(1'b0),
    .imem_ready(irdy3), .dmem_ready(drdy3),
    .imem_req(imem_req3), .dmem_req(dmem_req3), .dmem_we(dmem_we3),
    .ir_we(ir_we3), .pc_we(pc_we3), .pc_src(pcsrc3), .alu_op(aluop3),
    .alu_f3_zero(f3z3), .alu_src_a(srca3), .alu_src_b(srcb3),
    .aluout_we(aluout_we3), .rf_we(rf_we3), .wb_sel(wbsel3), .trap(trap3), .busy(busy3)
  );

  // Reference model: per-instruction totals (latency, strobe counts, selects)
  // derived from the instruction class and the chosen ready delays.
  task automatic run_instr(input logic [6:0] opc, input int di, input int dd,
                           input logic bt, input string tag);
    bit ld, st, br, jal, jalr, lui, fen, op, auipc;
    int exp_L, exp_dreq, exp_dwe, exp_alu, exp_rf, exp_pcwe;
    logic [1:0] exp_wb, exp_psrc, exp_aop, exp_sb;
    logic exp_f3z, exp_sa;
    int ic, dc, c_ireq, c_dreq, c_dwe, c_irwe, c_aluwe, c_rfwe, c_pcwe;
    logic [5:0] got_sel, pre_sel, prev_sel;
    logic [1:0] got_wb, got_psrc;
    logic first_ireq, last_ireq, trap_seen;

    ld = (opc == 7'b0000011); st = (opc == 7'b0100011); br = (opc == 7'b1100011);
    jal = (opc == 7'b1101111); jalr = (opc == 7'b1100111); lui = (opc == 7'b0110111);
    fen = (opc == 7'b0001111); op = (opc == 7'b0110011); auipc = (opc == 7'b0010111);

    exp_L    = di + 2 + (fen ? 0 : lui ? 1 : br ? 2 : st ? dd + 3 : ld ? dd + 4 : 3);
    exp_dreq = (ld || st) ? dd + 1 : 0;
    exp_dwe  = st ? dd + 1 : 0;
    exp_alu  = (fen || lui) ? 0 : 1;
    exp_rf   = (br || st || fen) ? 0 : 1;
    exp_pcwe = 1 + ((jal || jalr) ? 1 : 0) + ((br && bt) ? 1 : 0);
    exp_wb   = ld ? 2'b01 : (jal || jalr) ? 2'b10 : lui ? 2'b11 : 2'b00;
    exp_psrc = jalr ? 2'b10 : 2'b01;
    exp_aop  = op ? 2'b10 : br ? 2'b01 : 2'b00;
    exp_f3z  = ld || st || jalr || auipc || jal;
    exp_sa   = auipc || jal;
    exp_sb   = (op || br) ? 2'b00 : 2'b01;

    ic = 0; dc = 0; c_ireq = 0; c_dreq = 0; c_dwe = 0; c_irwe = 0;
    c_aluwe = 0; c_rfwe = 0; c_pcwe = 0;
    got_sel = 'x; pre_sel = 'x; prev_sel = 'x; got_wb = 'x; got_psrc = 'x;
    first_ireq = 1'bx; last_ireq = 1'bx; trap_seen = 1'b0;

    for (int c = 0; c < exp_L; c++) begin
      @(negedge clk);
      imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = bt;
      opcode = (c > di + 1) ? 7'($urandom) : opc;   // garbage after decode
      #1;
      if (imem_req) begin imem_ready = (ic == di); ic++; end
      if (dmem_req) begin dmem_ready = (dc == dd); dc++; end
      #1;
      if (c == 0) first_ireq = imem_req;
      if (imem_req)  c_ireq++;
      if (dmem_req)  c_dreq++;
      if (dmem_we)   c_dwe++;
      if (ir_we)     c_irwe++;
      if (aluout_we) c_aluwe++;
      if (rf_we)     c_rfwe++;
      if (pc_we)     c_pcwe++;
      if (aluout_we) begin
        got_sel = {alu_op, alu_f3_zero, alu_src_a, alu_src_b};
        pre_sel = prev_sel;
      end
      if (rf_we) got_wb = wb_sel;
      if (pc_we && !imem_req) got_psrc = pc_src;
      trap_seen |= trap;
      last_ireq = imem_req;
      prev_sel = {alu_op, alu_f3_zero, alu_src_a, alu_src_b};
    end

    n_chk++; if (first_ireq !== 1'b1) $display("FAIL %s fetch_start got %b want 1", tag, first_ireq); else n_pass++;
    n_chk++; if (last_ireq !== 1'b0) $display("FAIL %s last_cycle_ireq got %b want 0", tag, last_ireq); else n_pass++;
    n_chk++; if (c_ireq !== di + 1) $display("FAIL %s imem_req_cycles got %0d want %0d", tag, c_ireq, di + 1); else n_pass++;
    n_chk++; if (c_dreq !== exp_dreq) $display("FAIL %s dmem_req_cycles got %0d want %0d", tag, c_dreq, exp_dreq); else n_pass++;
    n_chk++; if (c_dwe !== exp_dwe) $display("FAIL %s dmem_we_cycles got %0d want %0d", tag, c_dwe, exp_dwe); else n_pass++;
    n_chk++; if (c_irwe !== 1) $display("FAIL %s ir_we_count got %0d want 1", tag, c_irwe); else n_pass++;
    n_chk++; if (c_aluwe !== exp_alu) $display("FAIL %s aluout_we_count got %0d want %0d", tag, c_aluwe, exp_alu); else n_pass++;
    n_chk++; if (c_rfwe !== exp_rf) $display("FAIL %s rf_we_count got %0d want %0d", tag, c_rfwe, exp_rf); else n_pass++;
    n_chk++; if (c_pcwe !== exp_pcwe) $display("FAIL %s pc_we_count got %0d want %0d", tag, c_pcwe, exp_pcwe); else n_pass++;
    n_chk++; if (trap_seen !== 1'b0) $display("FAIL %s trap got %b want 0", tag, trap_seen); else n_pass++;
    if (exp_alu == 1) begin
      n_chk++; if (got_sel !== {exp_aop, exp_f3z, exp_sa, exp_sb})
        $display("FAIL %s alu_sel_wait got %b want %b", tag, got_sel, {exp_aop, exp_f3z, exp_sa, exp_sb}); else n_pass++;
      n_chk++; if (pre_sel !== {exp_aop, exp_f3z, exp_sa, exp_sb})
        $display("FAIL %s alu_sel_exec got %b want %b", tag, pre_sel, {exp_aop, exp_f3z, exp_sa, exp_sb}); else n_pass++;
    end
    if (exp_rf == 1) begin
      n_chk++; if (got_wb !== exp_wb) $display("FAIL %s wb_sel got %b want %b", tag, got_wb, exp_wb); else n_pass++;
    end
    if (exp_pcwe > 1) begin
      n_chk++; if (got_psrc !== exp_psrc) $display("FAIL %s pc_src got %b want %b", tag, got_psrc, exp_psrc); else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [18:0] v;
    @(negedge clk); rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; #1;
    v = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op, alu_f3_zero, alu_src_a,
         alu_src_b, aluout_we, rf_we, wb_sel, trap, busy};
    n_chk++; if (v !== 19'b1) $display("FAIL reset_outputs got %b want %b", v, 19'b1); else n_pass++;
    @(negedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_add();     run_instr(7'b0110011, 0, 0, 1'b0, "add");     endtask
  task automatic test_load_late(); run_instr(7'b0000011, 0, 3, 1'b0, "lw_late"); endtask
  task automatic test_branch();
    run_instr(7'b1100011, 0, 0, 1'b1, "beq_taken");
    run_instr(7'b1100011, 0, 0, 1'b0, "beq_not_taken");
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 9)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), "rand");
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk); opcode = 7'b0100011; imem_ready = 1'b1; dmem_ready = 1'b0; #1;
    repeat (3) begin @(negedge clk); imem_ready = 1'b0; #1; end
    @(negedge clk); #1;
    n_chk++; if ({dmem_req, dmem_we} !== 2'b11) $display("FAIL store_in_mem got %b want 11", {dmem_req, dmem_we}); else n_pass++;
    rst = 1'b1; #1;
    n_chk++; if ({dmem_req, dmem_we, rf_we, pc_we} !== 4'b0)
      $display("FAIL rst_drops_req got %b want 0000", {dmem_req, dmem_we, rf_we, pc_we}); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if ({rf_we, pc_we} !== 2'b0) $display("FAIL rst_no_strobe got %b want 00", {rf_we, pc_we}); else n_pass++;
    rst = 1'b0; #1;
    n_chk++; if ({imem_req, dmem_req} !== 2'b10) $display("FAIL rst_to_fetch got %b want 10", {imem_req, dmem_req}); else n_pass++;
  endtask

  task automatic test_trap_illegal();
    logic bad;
    bad = 1'b0;
    @(negedge clk); opcode = 7'b1110011; imem_ready = 1'b1; dmem_ready = 1'b0; #1;
    @(negedge clk); imem_ready = 1'b0; #1;
    @(negedge clk); #1;
    n_chk++; if ({trap, busy} !== 2'b10) $display("FAIL illegal_trap got %b want 10", {trap, busy}); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      bad |= imem_req | dmem_req | ir_we | pc_we | aluout_we | rf_we | ~trap | busy;
    end
    n_chk++; if (bad !== 1'b0) $display("FAIL trap_hold got %b want 0", bad); else n_pass++;
    @(negedge clk); rst = 1'b1; #1;
    n_chk++; if ({trap, busy, imem_req} !== 3'b010) $display("FAIL trap_rst got %b want 010", {trap, busy, imem_req}); else n_pass++;
    @(negedge clk); rst = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1) $display("FAIL trap_release got %b want 1", imem_req); else n_pass++;
  endtask

  task automatic test_timeout();
    // imem never ready: 7 waiting fetch cycles, trap on the 8th
    @(negedge clk); rst3 = 1'b1; irdy3 = 1'b0; drdy3 = 1'b0; op3 = 7'b0110011; #1; rst3 = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk); #1;
      if (k == 7) begin
        n_chk++; if ({trap3, imem_req3} !== 2'b01) $display("FAIL to_before got %b want 01", {trap3, imem_req3}); else n_pass++;
      end
      if (k == 8) begin
        n_chk++; if ({trap3, busy3, imem_req3} !== 3'b100) $display("FAIL to_trap got %b want 100", {trap3, busy3, imem_req3}); else n_pass++;
      end
    end
    // ready on the 7th cycle wins
    @(negedge clk); rst3 = 1'b1; #1; rst3 = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk); irdy3 = (k == 7); #1;
      if (k == 7) begin
        n_chk++; if (ir_we3 !== 1'b1) $display("FAIL to_late_ready got %b want 1", ir_we3); else n_pass++;
      end
      if (k == 8) begin
        n_chk++; if ({trap3, busy3} !== 2'b01) $display("FAIL to_no_trap got %b want 01", {trap3, busy3}); else n_pass++;
      end
    end
    // data-side timeout on a load
    @(negedge clk); rst3 = 1'b1; op3 = 7'b0000011; #1; rst3 = 1'b0; irdy3 = 1'b1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk); irdy3 = 1'b0; #1;
      if (k == 11) begin
        n_chk++; if ({trap3, dmem_req3} !== 2'b01) $display("FAIL dto_before got %b want 01", {trap3, dmem_req3}); else n_pass++;
      end
      if (k == 12) begin
        n_chk++; if ({trap3, dmem_req3} !== 2'b10) $display("FAIL dto_trap got %b want 10", {trap3, dmem_req3}); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_late();
    test_branch();
    test_random();
    test_reset_mid_store();
    test_trap_illegal();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
